// File: rtl/pipelined_barrel_shifter.sv
// Pipelined rotate / logical / arithmetic barrel shifter with carry and zero flags.
// One register level captures the operation, then one stage per amount bit, LSB first.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 16,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  // p_*[k] is the operand presented to stage k; p_*[0] holds the captured input.
  logic [WIDTH-1:0] p_data  [AW];
  logic             p_valid [AW];
  logic             p_dir   [AW];
  logic [1:0]       p_mode  [AW];
  logic             p_sign  [AW];
  logic [AW-1:0]    p_amt   [AW];
  logic             p_carry [AW];

  logic [WIDTH-1:0] nx_data  [AW];
  logic             nx_carry [AW];

  logic stall;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Moves d by sh when hit is set; carry becomes the last bit dropped in shift modes.
  function automatic logic [WIDTH:0] stage_op(
    input logic [WIDTH-1:0] d,
    input logic             dir,
    input logic [1:0]       mode,
    input logic             sign,
    input logic             hit,
    input logic             carry,
    input int unsigned      sh
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] dropped;
    logic             co;
    logic             is_shift;
    r        = d;
    co       = carry;
    is_shift = (mode == 2'b01) || (mode == 2'b10);
    if (hit) begin
      if (dir) begin
        if (is_shift) begin
          r       = d << sh;
          dropped = d >> (WIDTH - sh);
          co      = dropped[0];
        end else begin
          r = (d << sh) | (d >> (WIDTH - sh));
        end
      end else begin
        if (is_shift) begin
          r = d >> sh;
          if (mode == 2'b10 && sign)
            r = r | ~({WIDTH{1'b1}} >> sh);
          dropped = d >> (sh - 1);
          co      = dropped[0];
        end else begin
          r = (d >> sh) | (d << (WIDTH - sh));
        end
      end
    end
    return {co, r};
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < AW; k++) begin
      {nx_carry[k], nx_data[k]} = stage_op(p_data[k], p_dir[k], p_mode[k], p_sign[k],
                                           p_amt[k][0], p_carry[k], 32'd1 << k);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < AW; k++) begin
        p_data[k]  <= '0;
        p_valid[k] <= 1'b0;
        p_dir[k]   <= 1'b0;
        p_mode[k]  <= '0;
        p_sign[k]  <= 1'b0;
        p_amt[k]   <= '0;
        p_carry[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
    end else if (!stall) begin
      p_data[0]  <= in_data;
      p_valid[0] <= in_valid;
      p_dir[0]   <= in_dir;
      p_mode[0]  <= in_mode;
      p_sign[0]  <= in_data[WIDTH-1];
      p_amt[0]   <= in_amt;
      p_carry[0] <= 1'b0;
      // Amount is consumed LSB first, so each stage passes on the remaining bits shifted down.
      for (int unsigned k = 1; k < AW; k++) begin
        p_data[k]  <= nx_data[k-1];
        p_valid[k] <= p_valid[k-1];
        p_dir[k]   <= p_dir[k-1];
        p_mode[k]  <= p_mode[k-1];
        p_sign[k]  <= p_sign[k-1];
        p_amt[k]   <= p_amt[k-1] >> 1;
        p_carry[k] <= nx_carry[k-1];
      end
      out_valid <= p_valid[AW-1];
      out_data  <= nx_data[AW-1];
      out_carry <= nx_carry[AW-1];
      out_zero  <= (nx_data[AW-1] == '0);
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: WIDTH=8/16/32 instances against a bit-level reference model.
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [4:0]  amt;
  logic        dir;
  logic [1:0]  mode;
  logic [2:0]  vld;
  logic [2:0]  ordy;
  logic [2:0]  irdy, ov, oc, oz;
  logic [7:0]  od8;
  logic [15:0] od16;
  logic [31:0] od32;

  logic [1:0]  sel;
  logic        cur_ov, cur_oc, cur_oz, cur_ir;
  logic [31:0] cur_od;

  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst), .in_valid(vld[0]), .in_ready(irdy[0]), .in_data(din[7:0]),
    .in_amt(amt[2:0]), .in_dir(dir), .in_mode(mode), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od8), .out_carry(oc[0]), .out_zero(oz[0]));

  pipelined_barrel_shifter #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(rst), .in_valid(vld[1]), .in_ready(irdy[1]), .in_data(din[15:0]),
    .in_amt(amt[3:0]), .in_dir(dir), .in_mode(mode), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od16), .out_carry(oc[1]), .out_zero(oz[1]));

  pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst), .in_valid(vld[2]), .in_ready(irdy[2]), .in_data(din),
    .in_amt(amt), .in_dir(dir), .in_mode(mode), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od32), .out_carry(oc[2]), .out_zero(oz[2]));

  always_comb begin
    case (sel)
      2'd0:    begin cur_ov = ov[0]; cur_oc = oc[0]; cur_oz = oz[0]; cur_ir = irdy[0]; cur_od = {24'b0, od8};  end
      2'd1:    begin cur_ov = ov[1]; cur_oc = oc[1]; cur_oz = oz[1]; cur_ir = irdy[1]; cur_od = {16'b0, od16}; end
      default: begin cur_ov = ov[2]; cur_oc = oc[2]; cur_oz = oz[2]; cur_ir = irdy[2]; cur_od = od32;          end
    endcase
  end

  // Output transfers of the selected instance, sampled mid-cycle before the edge that takes them.
  always @(negedge clk) begin
    if (cur_ov && ordy[sel])
      got_q.push_back({cur_oz, cur_oc, cur_od});
  end

  function automatic int unsigned w_of(input logic [1:0] s);
    return (s == 2'd0) ? 8 : ((s == 2'd1) ? 16 : 32);
  endfunction

  function automatic logic bit_of(input logic [31:0] d, input int unsigned i);
    logic [31:0] t;
    t = d >> i;
    return t[0];
  endfunction

  // Reference: each result bit taken from its source position by index arithmetic.
  function automatic logic [33:0] ref_op(input logic [31:0] d, input int unsigned a,
                                         input logic dr, input logic [1:0] m, input int unsigned w);
    logic [31:0] r;
    logic        c, b, sh;
    r  = '0;
    c  = 1'b0;
    sh = (m == 2'd1) || (m == 2'd2);
    for (int unsigned i = 0; i < w; i++) begin
      if (!sh)
        b = dr ? bit_of(d, (i + w - a) % w) : bit_of(d, (i + a) % w);
      else if (dr)
        b = (i >= a) ? bit_of(d, i - a) : 1'b0;
      else
        b = (i + a < w) ? bit_of(d, i + a) : (m == 2'd2 && bit_of(d, w - 1));
      r = r | ({31'b0, b} << i);
    end
    if (sh && a != 0)
      c = dr ? bit_of(d, w - a) : bit_of(d, a - 1);
    return {(r == 32'b0), c, r};
  endfunction

  task automatic issue(input logic [31:0] d, input int unsigned a, input logic dr, input logic [1:0] m);
    logic ok;
    din = d; amt = a[4:0]; dir = dr; mode = m;
    vld = '0;
    vld[sel] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cur_ir;
      @(posedge clk); #1;
    end
    vld = '0;
    exp_q.push_back(ref_op(d, a, dr, m, w_of(sel)));
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL accept: in_ready never seen (got %0b, need 1)", ok);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = '0; ordy = '1; din = '0; amt = '0; dir = 1'b0; mode = '0; sel = 2'd1;
    #12;
    n_cmp++; if (ov !== 3'b000) begin n_bad++; $display("FAIL reset_valid: got %b need 000", ov); end
    n_cmp++; if (od16 !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h need 0000", od16); end
    n_cmp++; if (oc !== 3'b000) begin n_bad++; $display("FAIL reset_carry: got %b need 000", oc); end
    n_cmp++; if (oz !== 3'b000) begin n_bad++; $display("FAIL reset_zero: got %b need 000", oz); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (irdy !== 3'b111) begin n_bad++; $display("FAIL reset_ready: got %b need 111", irdy); end
  endtask

  task automatic test_directed();
    logic [15:0] dv [9] = '{16'h8001, 16'h8001, 16'hF00F, 16'h8000, 16'h8000, 16'h7FF0, 16'hC001, 16'h1234, 16'hA5A5};
    int unsigned av [9] = '{1, 4, 4, 1, 15, 4, 1, 4, 0};
    logic        rv [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  mv [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd1};
    logic [15:0] ed [9] = '{16'hC000, 16'h0018, 16'h0F00, 16'h0000, 16'hFFFF, 16'h07FF, 16'h8002, 16'h2341, 16'hA5A5};
    logic        ec [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        ez [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int n;
    sel = 2'd1;
    for (int i = 0; i < 9; i++) begin
      issue({16'b0, dv[i]}, av[i], rv[i], mv[i]);
      n = 0;
      while (!ov[1] && n < 20) begin @(posedge clk); #1; n++; end
      n_cmp++; if (n != 4) begin n_bad++; $display("FAIL dir%0d_latency: got %0d need 4", i, n); end
      n_cmp++; if (od16 !== ed[i]) begin n_bad++; $display("FAIL dir%0d_data: got %h need %h", i, od16, ed[i]); end
      n_cmp++; if (oc[1] !== ec[i]) begin n_bad++; $display("FAIL dir%0d_carry: got %b need %b", i, oc[1], ec[i]); end
      n_cmp++; if (oz[1] !== ez[i]) begin n_bad++; $display("FAIL dir%0d_zero: got %b need %b", i, oz[1], ez[i]); end
      @(posedge clk); #1;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [33:0] hold;
    logic [33:0] e, g;
    sel = 2'd1;
    exp_q.delete(); got_q.delete();
    fork
      begin
        for (int i = 0; i < 8; i++)
          issue({16'b0, 16'($urandom)}, $urandom_range(0, 15), 1'($urandom), 2'($urandom));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        ordy[1] = 1'b0;
        hold = {cur_oz, cur_oc, cur_od};
        n_cmp++; if (cur_ov !== 1'b1) begin n_bad++; $display("FAIL b2b_stall_valid: got %b need 1", cur_ov); end
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          n_cmp++; if (irdy[1] !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_ready%0d: got %b need 0", c, irdy[1]); end
          n_cmp++; if ({cur_oz, cur_oc, cur_od} !== hold) begin
            n_bad++; $display("FAIL b2b_hold%0d: got %h need %h", c, {cur_oz, cur_oc, cur_od}, hold);
          end
        end
        @(posedge clk); #1;
        ordy[1] = 1'b1;
      end
    join
    for (int i = 0; i < 60 && got_q.size() < 8; i++) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() != 8) begin n_bad++; $display("FAIL b2b_count: got %0d need 8", got_q.size()); end
    for (int i = 0; i < 8 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_result%0d: got %h need %h", i, g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midstream();
    int stale, n;
    sel = 2'd1;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 3; i++)
      issue({16'b0, 16'($urandom)}, $urandom_range(1, 15), 1'($urandom), 2'($urandom));
    rst = 1'b1;
    #1;
    n_cmp++; if (ov[1] !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b need 0", ov[1]); end
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 0;
    repeat (8) begin @(negedge clk); if (ov[1]) stale++; end
    n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL mid_reset_stale: got %0d need 0", stale); end
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL mid_reset_queue: got %0d need 0", got_q.size()); end
    @(posedge clk); #1;
    issue(32'h0000_00F0, 4, 1'b0, 2'd1);
    n = 0;
    while (!ov[1] && n < 20) begin @(posedge clk); #1; n++; end
    n_cmp++; if (n != 4) begin n_bad++; $display("FAIL mid_reset_latency: got %0d need 4", n); end
    n_cmp++; if ({oz[1], oc[1], od16} !== {1'b0, 1'b0, 16'h000F}) begin
      n_bad++; $display("FAIL mid_reset_result: got %h need %h", {oz[1], oc[1], od16}, {1'b0, 1'b0, 16'h000F});
    end
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_regression(input logic [1:0] s, input int total);
    int unsigned w;
    logic [31:0] mask;
    logic done;
    logic [33:0] e, g;
    int expected;
    sel = s;
    w = w_of(s);
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    exp_q.delete(); got_q.delete();
    done = 1'b0;
    fork
      begin
        for (int m = 0; m < 4; m++)
          for (int r = 0; r < 2; r++) begin
            issue($urandom & mask, 0, 1'(r), 2'(m));
            issue($urandom & mask, w - 1, 1'(r), 2'(m));
          end
        for (int i = 16; i < total; i++) begin
          if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
          issue($urandom & mask, $urandom_range(0, w - 1), 1'($urandom), 2'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ordy[s] = ($urandom_range(0, 3) != 0);
        end
        ordy[s] = 1'b1;
      end
    join
    expected = exp_q.size();
    for (int i = 0; i < 100 && got_q.size() < expected; i++) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() != expected) begin
      n_bad++; $display("FAIL regr%0d_count: got %0d need %0d", w, got_q.size(), expected);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL regr%0d_result: got %h need %h", w, g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, need finish)");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_regression(2'd1, 200);
    test_regression(2'd2, 1000);
    test_regression(2'd0, 1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
